dispense_scheduler: RTL and testbench

DISPENSE_SCHEDULER -- requirements
Module: dispense_scheduler

---
 rtl/dispense_scheduler.sv | 176 +++++++++++++++++
 tb/tb_dispense_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_scheduler.sv
// Two-kiosk vending dispense scheduler.
// Requests from two kiosks are arbitrated round-robin. The winner's product
// choice is latched at grant time. A grant either runs that product's motor for
// a fixed number of cycles and acks, or naks at once when the product is out of
// stock. Every output is a register, so outputs change only on a clock edge or
// on reset.
module dispense_scheduler #(
  parameter int MAX_STOCK    = 7,
  parameter int MOTOR_CYCLES = 4
) (
  input  logic       clk1,
  input  logic       reset1,
  input  logic       req0,
  input  logic       req1,
  input  logic       sel0,
  input  logic       sel1,
  input  logic       restock,
  output logic       ack0,
  output logic       ack1,
  output logic       nak0,
  output logic       nak1,
  output logic       motor_a,
  output logic       motor_b,
  output logic [2:0] stock_a,
  output logic [2:0] stock_b,
  output logic       busy
);

  localparam logic [2:0] FULL       = 3'(MAX_STOCK);
  localparam logic [3:0] MOTOR_LAST = 4'(MOTOR_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DRIVE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic       winner, winner_nxt;    // kiosk being served: 0 or 1
  logic       product, product_nxt;  // latched product: 0 = A, 1 = B
  logic       last, last_nxt;        // kiosk served most recently
  logic       pending, pending_nxt;  // restock seen while busy
  logic [3:0] count, count_nxt;      // motor on-time elapsed
  logic [2:0] stock_a_nxt, stock_b_nxt;
  logic       ack0_nxt, ack1_nxt, nak0_nxt, nak1_nxt;
  logic       motor_a_nxt, motor_b_nxt, busy_nxt;
  logic       grant;
  logic       winner_req;
  logic       sel_empty;

  // A stock count only ever moves down by one. It stops at zero and never wraps.
  function automatic logic [2:0] dec_sat(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // Next-state logic, plus the next value of every registered output
  always_comb begin
    state_nxt   = state;
    winner_nxt  = winner;
    product_nxt = product;
    last_nxt    = last;
    pending_nxt = pending;
    count_nxt   = count;
    stock_a_nxt = stock_a;
    stock_b_nxt = stock_b;
    ack0_nxt    = 1'b0;
    ack1_nxt    = 1'b0;
    nak0_nxt    = 1'b0;
    nak1_nxt    = 1'b0;
    motor_a_nxt = 1'b0;
    motor_b_nxt = 1'b0;
    // On a tie, grant the kiosk that was not served last. A lone requester
    // always wins.
    grant       = (req0 && req1) ? ~last : req1;
    winner_req  = winner ? req1 : req0;
    sel_empty   = product ? (stock_b == 3'd0) : (stock_a == 3'd0);

    case (state)
      IDLE: begin
        if (restock) begin
          // A refill takes this cycle, so no request is granted in it.
          stock_a_nxt = FULL;
          stock_b_nxt = FULL;
        end else if (req0 || req1) begin
          winner_nxt  = grant;
          product_nxt = grant ? sel1 : sel0;
          state_nxt   = CHECK;
        end
      end
      CHECK: begin
        if (restock) pending_nxt = 1'b1;
        if (sel_empty) begin
          state_nxt = DONE;
          nak0_nxt  = ~winner;
          nak1_nxt  = winner;
        end else begin
          if (product) stock_b_nxt = dec_sat(stock_b);
          else         stock_a_nxt = dec_sat(stock_a);
          count_nxt   = 4'd1;
          motor_a_nxt = ~product;
          motor_b_nxt = product;
          state_nxt   = DRIVE;
        end
      end
      DRIVE: begin
        if (restock) pending_nxt = 1'b1;
        if (count == MOTOR_LAST) begin
          state_nxt = DONE;
          ack0_nxt  = ~winner;
          ack1_nxt  = winner;
        end else begin
          count_nxt   = count + 4'd1;
          motor_a_nxt = ~product;
          motor_b_nxt = product;
        end
      end
      DONE: begin
        if (!winner_req) begin
          // A deferred refill is applied here, before any new grant is made.
          state_nxt   = IDLE;
          last_nxt    = winner;
          pending_nxt = 1'b0;
          if (pending || restock) begin
            stock_a_nxt = FULL;
            stock_b_nxt = FULL;
          end
        end else if (restock) begin
          pending_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers. Reset takes effect at once, without waiting
  // for a clock edge.
  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      state   <= IDLE;
      winner  <= 1'b0;
      product <= 1'b0;
      last    <= 1'b1;
      pending <= 1'b0;
      count   <= 4'd0;
      stock_a <= FULL;
      stock_b <= FULL;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      nak0    <= 1'b0;
      nak1    <= 1'b0;
      motor_a <= 1'b0;
      motor_b <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      winner  <= winner_nxt;
      product <= product_nxt;
      last    <= last_nxt;
      pending <= pending_nxt;
      count   <= count_nxt;
      stock_a <= stock_a_nxt;
      stock_b <= stock_b_nxt;
      ack0    <= ack0_nxt;
      ack1    <= ack1_nxt;
      nak0    <= nak0_nxt;
      nak1    <= nak1_nxt;
      motor_a <= motor_a_nxt;
      motor_b <= motor_b_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_dispense_scheduler.sv
// Self-checking bench for dispense_scheduler.
// It runs directed scenarios and then randomized rounds. The randomized rounds
// are checked against a transaction-level model of stock, arbitration and
// response timing.
module tb_dispense_scheduler;

  localparam int MAX = 7;
  localparam int MC  = 4;

  logic       clk1 = 1'b0;
  logic       reset1, req0, req1, sel0, sel1, restock;
  logic       ack0, ack1, nak0, nak1, motor_a, motor_b, busy;
  logic [2:0] stock_a, stock_b;

  int checks = 0;
  int errors = 0;

  // Reference model state: stock per product, and the kiosk served last.
  int ma, mb, last_srv;

  dispense_scheduler #(.MAX_STOCK(MAX), .MOTOR_CYCLES(MC)) dut (
    .clk1(clk1), .reset1(reset1),
    .req0(req0), .req1(req1), .sel0(sel0), .sel1(sel1), .restock(restock),
    .ack0(ack0), .ack1(ack1), .nak0(nak0), .nak1(nak1),
    .motor_a(motor_a), .motor_b(motor_b),
    .stock_a(stock_a), .stock_b(stock_b), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; sel0 = 1'b0; sel1 = 1'b0; restock = 1'b0;
    reset1 = 1'b1;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    reset1 = 1'b0;
    @(posedge clk1); #1;
  endtask

  // Runs one request round and reports what it observed; it compares nothing.
  // It must be called just after a clock edge, with the DUT idle.
  task automatic do_round(input bit r0, input bit s0, input bit r1, input bit s1,
                          input int rs_at, input int hold,
                          output int granted, output bit got_ack, output int resp_k,
                          output int cnt_a, output int cnt_b, output int viol,
                          output int pulses, output int stk_a2, output bit timeout);
    int held;
    bit dropped;
    int n;
    granted = -1; got_ack = 1'b0; resp_k = -1; cnt_a = 0; cnt_b = 0; viol = 0;
    pulses = 0; stk_a2 = -1; timeout = 1'b1; held = 0; dropped = 1'b0;
    req0 = r0; sel0 = s0; req1 = r1; sel1 = s1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk1); #1;
      restock = 1'b0;
      n = int'(ack0) + int'(ack1) + int'(nak0) + int'(nak1);
      if (n > 1) viol++;
      if (motor_a && motor_b) viol++;
      if (motor_a) cnt_a++;
      if (motor_b) cnt_b++;
      pulses += n;
      if (k == 2) stk_a2 = int'(stock_a);
      if (n > 0 && granted < 0) begin
        granted = (ack0 || nak0) ? 0 : 1;
        got_ack = ack0 || ack1;
        resp_k  = k;
      end
      if (dropped) begin
        if (!busy) begin
          timeout = 1'b0;
          break;
        end
      end else if (granted >= 0) begin
        if (held >= hold) begin
          req0 = 1'b0; req1 = 1'b0; dropped = 1'b1;
        end else begin
          if (!busy) viol++;
          held++;
        end
      end
      // The product choice was latched at grant, so later changes must not matter.
      if (!dropped) begin
        sel0 = 1'($urandom_range(0, 1));
        sel1 = 1'($urandom_range(0, 1));
      end
      if (k == rs_at) restock = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0; restock = 1'b0;
  endtask

  // Applies one round to the model and updates its stock and last-served kiosk.
  task automatic predict(input bit r0, input bit s0, input bit r1, input bit s1,
                         input bit rs_mid, output int w, output int prod, output bit ok);
    if (r0 && r1) w = (last_srv == 0) ? 1 : 0;
    else          w = r1 ? 1 : 0;
    prod = (w == 1) ? int'(s1) : int'(s0);
    if (prod == 0) begin ok = (ma > 0); if (ok) ma = ma - 1; end
    else           begin ok = (mb > 0); if (ok) mb = mb - 1; end
    last_srv = w;
    if (rs_mid) begin ma = MAX; mb = MAX; end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({ack0, ack1, nak0, nak1} !== 4'b0) begin errors++; $display("FAIL reset_acknak got %b want 0000", {ack0, ack1, nak0, nak1}); end
    checks++; if ({motor_a, motor_b} !== 2'b00) begin errors++; $display("FAIL reset_motor got %b want 00", {motor_a, motor_b}); end
    checks++; if (stock_a !== 3'(MAX) || stock_b !== 3'(MAX)) begin errors++; $display("FAIL reset_stock got %0d/%0d want %0d/%0d", stock_a, stock_b, MAX, MAX); end
  endtask

  task automatic test_single();
    int g, rk, ca, cb, v, np, sa2; bit ga, to;
    do_reset();
    do_round(1, 0, 0, 0, -1, 0, g, ga, rk, ca, cb, v, np, sa2, to);
    checks++; if (g !== 0 || ga !== 1'b1) begin errors++; $display("FAIL single_resp got kiosk %0d ack %b want kiosk 0 ack 1", g, ga); end
    checks++; if (rk !== MC + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", rk, MC + 2); end
    checks++; if (ca !== MC || cb !== 0) begin errors++; $display("FAIL single_motor got a=%0d b=%0d want a=%0d b=0", ca, cb, MC); end
    checks++; if (stock_a !== 3'd6 || stock_b !== 3'(MAX)) begin errors++; $display("FAIL single_stock got %0d/%0d want 6/%0d", stock_a, stock_b, MAX); end
    checks++; if (np !== 1 || v !== 0 || to !== 1'b0) begin errors++; $display("FAIL single_proto got pulses=%0d viol=%0d timeout=%b want 1/0/0", np, v, to); end
  endtask

  task automatic test_round_robin();
    int g, rk, ca, cb, v, np, sa2; bit ga, to;
    int want[3] = '{0, 1, 0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_round(1, 1, 1, 1, -1, 0, g, ga, rk, ca, cb, v, np, sa2, to);
      checks++; if (g !== want[i] || ga !== 1'b1) begin errors++; $display("FAIL rr_grant%0d got kiosk %0d ack %b want kiosk %0d ack 1", i, g, ga, want[i]); end
      checks++; if (cb !== MC || ca !== 0 || v !== 0) begin errors++; $display("FAIL rr_motor%0d got a=%0d b=%0d viol=%0d want a=0 b=%0d viol=0", i, ca, cb, v, MC); end
    end
    checks++; if (stock_b !== 3'd4 || stock_a !== 3'(MAX)) begin errors++; $display("FAIL rr_stock got %0d/%0d want %0d/4", stock_a, stock_b, MAX); end
  endtask

  task automatic test_out_of_stock();
    int g, rk, ca, cb, v, np, sa2; bit ga, to;
    do_reset();
    repeat (MAX) do_round(1, 0, 0, 0, -1, 0, g, ga, rk, ca, cb, v, np, sa2, to);
    checks++; if (stock_a !== 3'd0) begin errors++; $display("FAIL drain_stock got %0d want 0", stock_a); end
    do_round(0, 0, 1, 0, -1, 0, g, ga, rk, ca, cb, v, np, sa2, to);
    checks++; if (g !== 1 || ga !== 1'b0) begin errors++; $display("FAIL nak_resp got kiosk %0d ack %b want kiosk 1 ack 0", g, ga); end
    checks++; if (rk !== 2 || np !== 1) begin errors++; $display("FAIL nak_timing got k=%0d pulses=%0d want k=2 pulses=1", rk, np); end
    checks++; if (ca !== 0 || cb !== 0) begin errors++; $display("FAIL nak_motor got a=%0d b=%0d want 0/0", ca, cb); end
    checks++; if (stock_a !== 3'd0 || stock_b !== 3'(MAX)) begin errors++; $display("FAIL nak_stock got %0d/%0d want 0/%0d", stock_a, stock_b, MAX); end
  endtask

  task automatic test_restock_drive();
    int g, rk, ca, cb, v, np, sa2; bit ga, to;
    do_reset();
    repeat (4) do_round(1, 0, 0, 0, -1, 0, g, ga, rk, ca, cb, v, np, sa2, to);
    checks++; if (stock_a !== 3'd3) begin errors++; $display("FAIL rsd_setup got %0d want 3", stock_a); end
    do_round(1, 0, 0, 0, 3, 0, g, ga, rk, ca, cb, v, np, sa2, to);
    checks++; if (sa2 !== 2) begin errors++; $display("FAIL rsd_after_check got %0d want 2", sa2); end
    checks++; if (g !== 0 || ga !== 1'b1 || ca !== MC || np !== 1) begin errors++; $display("FAIL rsd_ack got kiosk %0d ack %b motor %0d pulses %0d want 0/1/%0d/1", g, ga, ca, np, MC); end
    checks++; if (stock_a !== 3'(MAX) || stock_b !== 3'(MAX)) begin errors++; $display("FAIL rsd_reload got %0d/%0d want %0d/%0d", stock_a, stock_b, MAX, MAX); end
  endtask

  task automatic test_restock_idle();
    int g, rk, ca, cb, v, np, sa2; bit ga, to;
    do_reset();
    repeat (2) do_round(1, 0, 0, 0, -1, 0, g, ga, rk, ca, cb, v, np, sa2, to);
    restock = 1'b1; req0 = 1'b1; sel0 = 1'b0;
    @(posedge clk1); #1;
    restock = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsi_suppress got busy %b want 0", busy); end
    checks++; if (stock_a !== 3'(MAX)) begin errors++; $display("FAIL rsi_refill got %0d want %0d", stock_a, MAX); end
    do_round(1, 0, 0, 0, -1, 0, g, ga, rk, ca, cb, v, np, sa2, to);
    checks++; if (ga !== 1'b1 || stock_a !== 3'(MAX - 1)) begin errors++; $display("FAIL rsi_after got ack %b stock %0d want 1/%0d", ga, stock_a, MAX - 1); end
  endtask

  task automatic test_reset_drive();
    int seen;
    do_reset();
    req0 = 1'b1; sel0 = 1'b1;
    repeat (3) begin @(posedge clk1); #1; end
    checks++; if (motor_b !== 1'b1 || stock_b !== 3'(MAX - 1)) begin errors++; $display("FAIL rstd_pre got motor %b stock %0d want 1/%0d", motor_b, stock_b, MAX - 1); end
    #2 reset1 = 1'b1;
    #1;
    checks++; if (motor_b !== 1'b0 || motor_a !== 1'b0) begin errors++; $display("FAIL rstd_motor got %b%b want 00", motor_a, motor_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstd_busy got %b want 0", busy); end
    checks++; if (stock_a !== 3'(MAX) || stock_b !== 3'(MAX)) begin errors++; $display("FAIL rstd_stock got %0d/%0d want %0d/%0d", stock_a, stock_b, MAX, MAX); end
    req0 = 1'b0;
    @(negedge clk1);
    reset1 = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk1); #1;
      seen += int'(ack0) + int'(ack1) + int'(motor_a) + int'(motor_b) + int'(busy);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstd_quiet got %0d activity samples want 0", seen); end
  endtask

  task automatic test_hold();
    int g, rk, ca, cb, v, np, sa2; bit ga, to;
    do_reset();
    do_round(1, 0, 0, 0, -1, 5, g, ga, rk, ca, cb, v, np, sa2, to);
    checks++; if (np !== 1 || ga !== 1'b1) begin errors++; $display("FAIL hold_pulse got pulses %0d ack %b want 1/1", np, ga); end
    checks++; if (ca !== MC || cb !== 0) begin errors++; $display("FAIL hold_motor got a=%0d b=%0d want %0d/0", ca, cb, MC); end
    checks++; if (v !== 0 || to !== 1'b0) begin errors++; $display("FAIL hold_done got viol %0d timeout %b want 0/0", v, to); end
    checks++; if (stock_a !== 3'(MAX - 1)) begin errors++; $display("FAIL hold_stock got %0d want %0d", stock_a, MAX - 1); end
  endtask

  task automatic test_random();
    do_reset();
    ma = MAX; mb = MAX; last_srv = 1;
    for (int i = 0; i < 60; i++) begin
      bit r0, r1, s0, s1, rs_mid, ok, ga, to;
      int w, prod, rs_at, g, rk, ca, cb, v, np, sa2;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      s0 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        restock = 1'b1;
        @(posedge clk1); #1;
        restock = 1'b0;
        ma = MAX; mb = MAX;
      end
      rs_mid = ($urandom_range(0, 15) == 0);
      predict(r0, s0, r1, s1, rs_mid, w, prod, ok);
      rs_at = rs_mid ? (ok ? int'($urandom_range(1, MC + 1)) : 1) : -1;
      do_round(r0, s0, r1, s1, rs_at, int'($urandom_range(0, 2)), g, ga, rk, ca, cb, v, np, sa2, to);
      checks++; if (g !== w || ga !== ok) begin errors++; $display("FAIL rnd%0d_resp got kiosk %0d ack %b want kiosk %0d ack %b", i, g, ga, w, ok); end
      checks++; if (rk !== (ok ? MC + 2 : 2)) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, rk, ok ? MC + 2 : 2); end
      checks++; if (ca !== ((ok && prod == 0) ? MC : 0) || cb !== ((ok && prod == 1) ? MC : 0)) begin errors++; $display("FAIL rnd%0d_motor got a=%0d b=%0d product %0d ok %b", i, ca, cb, prod, ok); end
      checks++; if (v !== 0 || np !== 1 || to !== 1'b0) begin errors++; $display("FAIL rnd%0d_proto got viol %0d pulses %0d timeout %b want 0/1/0", i, v, np, to); end
      checks++; if (int'(stock_a) !== ma || int'(stock_b) !== mb) begin errors++; $display("FAIL rnd%0d_stock got %0d/%0d want %0d/%0d", i, stock_a, stock_b, ma, mb); end
    end
  endtask

  initial begin
    reset1 = 1'b1;
    req0 = 1'b0; req1 = 1'b0; sel0 = 1'b0; sel1 = 1'b0; restock = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_out_of_stock();
    test_restock_drive();
    test_restock_idle();
    test_reset_drive();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
